// File: rtl/alu_load_sequencer_if.sv
// Command channel into the ALU load sequencer.
// valid/ready handshake plus operands, op code and load enables.
interface alu_load_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [3:0]  cmd_op;
  logic        cmd_load_a;
  logic        cmd_load_b;

  modport master (
    output cmd_valid,
    output cmd_a,
    output cmd_b,
    output cmd_op,
    output cmd_load_a,
    output cmd_load_b,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_a,
    input  cmd_b,
    input  cmd_op,
    input  cmd_load_a,
    input  cmd_load_b,
    output cmd_ready
  );
endinterface

// File: rtl/alu_load_sequencer.sv
// Drives multi_alu sw/ld_a/ld_b/ld_f from one command, then captures flags.
// Ports: clk, rst, cmd (slave), sw, ld_a/ld_b/ld_f, fr_in, fr_out, done, busy.
module alu_load_sequencer #(
  parameter int SETUP_CYC  = 1,
  parameter int PULSE_CYC  = 1,
  parameter int SETTLE_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_load_sequencer_if.slave   cmd,
  output logic [31:0]           sw,
  output logic                  ld_a,
  output logic                  ld_b,
  output logic                  ld_f,
  input  logic [3:0]            fr_in,
  output logic [3:0]            fr_out,
  output logic                  done,
  output logic                  busy
);

  typedef enum logic [3:0] {
    IDLE,
    A_SETUP, A_PULSE, A_HOLD,
    B_SETUP, B_PULSE, B_HOLD,
    F_SETUP, F_PULSE, F_HOLD,
    SETTLE, DONE
  } state_e;

  localparam logic [3:0] SETUP_RL  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] PULSE_RL  = 4'(PULSE_CYC - 1);
  localparam logic [3:0] SETTLE_RL = 4'(SETTLE_CYC - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] sw_q, sw_d;
  logic        ld_a_q, ld_a_d;
  logic        ld_b_q, ld_b_d;
  logic        ld_f_q, ld_f_d;
  logic [3:0]  fr_q, fr_d;
  logic        done_q, done_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  op_q, op_d;
  logic        lb_q, lb_d;

  logic        accept;
  logic        last;
  logic        entry;
  logic [31:0] src_a, src_b;
  logic [3:0]  src_op;

  always_comb begin
    accept = cmd.cmd_valid && (state_q == IDLE);
    last   = (cnt_q == 4'd0);
    // On the accept edge the command registers are not loaded yet,
    // so the first phase value comes straight from the bus.
    src_a  = accept ? cmd.cmd_a  : a_q;
    src_b  = accept ? cmd.cmd_b  : b_q;
    src_op = accept ? cmd.cmd_op : op_q;

    a_d  = a_q;
    b_d  = b_q;
    op_d = op_q;
    lb_d = lb_q;
    if (accept) begin
      a_d  = cmd.cmd_a;
      b_d  = cmd.cmd_b;
      op_d = cmd.cmd_op;
      lb_d = cmd.cmd_load_b;
    end

    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (cmd.cmd_load_a)      state_d = A_SETUP;
          else if (cmd.cmd_load_b) state_d = B_SETUP;
          else                     state_d = F_SETUP;
        end
      end
      A_SETUP: if (last) state_d = A_PULSE;
      A_PULSE: if (last) state_d = A_HOLD;
      A_HOLD:  state_d = lb_q ? B_SETUP : F_SETUP;
      B_SETUP: if (last) state_d = B_PULSE;
      B_PULSE: if (last) state_d = B_HOLD;
      B_HOLD:  state_d = F_SETUP;
      F_SETUP: if (last) state_d = F_PULSE;
      F_PULSE: if (last) state_d = F_HOLD;
      F_HOLD:  state_d = SETTLE;
      SETTLE:  if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    entry = (state_d != state_q);

    cnt_d = cnt_q;
    if (entry) begin
      unique case (1'b1)
        (state_d == A_SETUP) ||
        (state_d == B_SETUP) ||
        (state_d == F_SETUP): cnt_d = SETUP_RL;
        (state_d == A_PULSE) ||
        (state_d == B_PULSE) ||
        (state_d == F_PULSE): cnt_d = PULSE_RL;
        (state_d == SETTLE):  cnt_d = SETTLE_RL;
        default:              cnt_d = 4'd0;
      endcase
    end else if (!last) begin
      cnt_d = cnt_q - 4'd1;
    end

    sw_d = sw_q;
    if (entry) begin
      unique case (1'b1)
        (state_d == A_SETUP): sw_d = src_a;
        (state_d == B_SETUP): sw_d = src_b;
        (state_d == F_SETUP): sw_d = {src_op, 28'h0};
        default:              sw_d = sw_q;
      endcase
    end

    // Strobes and done come from the next state so they leave a flop.
    ld_a_d = (state_d == A_PULSE);
    ld_b_d = (state_d == B_PULSE);
    ld_f_d = (state_d == F_PULSE);
    done_d = (state_d == DONE);

    fr_d = fr_q;
    if ((state_q == SETTLE) && last) fr_d = fr_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sw_q    <= 32'h0;
      ld_a_q  <= 1'b0;
      ld_b_q  <= 1'b0;
      ld_f_q  <= 1'b0;
      fr_q    <= 4'h0;
      done_q  <= 1'b0;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      op_q    <= 4'h0;
      lb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sw_q    <= sw_d;
      ld_a_q  <= ld_a_d;
      ld_b_q  <= ld_b_d;
      ld_f_q  <= ld_f_d;
      fr_q    <= fr_d;
      done_q  <= done_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      lb_q    <= lb_d;
    end
  end

  assign cmd.cmd_ready = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign sw            = sw_q;
  assign ld_a          = ld_a_q;
  assign ld_b          = ld_b_q;
  assign ld_f          = ld_f_q;
  assign fr_out        = fr_q;
  assign done          = done_q;

endmodule

// File: tb/tb_alu_load_sequencer.sv
// Directed bench for alu_load_sequencer.
// Strobe events are scoreboarded against expectations pushed at drive time.
module tb_alu_load_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sw;
  logic        ld_a, ld_b, ld_f;
  logic [3:0]  fr_in;
  logic [3:0]  fr_out;
  logic        done;
  logic        busy;

  alu_load_sequencer_if cif();

  alu_load_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .cmd    (cif),
    .sw     (sw),
    .ld_a   (ld_a),
    .ld_b   (ld_b),
    .ld_f   (ld_f),
    .fr_in  (fr_in),
    .fr_out (fr_out),
    .done   (done),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [33:0] exp_q[$];
  logic [33:0] obs_q[$];
  int          rd_idx   = 0;
  int          done_cnt = 0;
  int          multi_cnt = 0;
  logic        pa = 1'b0, pb = 1'b0, pf = 1'b0;

  // Event monitor: each strobe rising edge logs {id, sw}.
  always @(negedge clk) begin
    if (ld_a && !pa) obs_q.push_back({2'd1, sw});
    if (ld_b && !pb) obs_q.push_back({2'd2, sw});
    if (ld_f && !pf) obs_q.push_back({2'd3, sw});
    if ((ld_a && ld_b) || (ld_a && ld_f) || (ld_b && ld_f))
      multi_cnt++;
    if (done) done_cnt++;
    pa = ld_a;
    pb = ld_b;
    pf = ld_f;
  end

  task automatic chk(input string tag, input logic [33:0] obs,
                     input logic [33:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drain(input string tag);
    logic [33:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd_idx < obs_q.size()) begin
        chk({tag, "_ev"}, obs_q[rd_idx], e);
        rd_idx++;
      end else begin
        chk({tag, "_ev_missing"}, {2'd3, 32'hFFFF_FFFF}, e);
      end
    end
    chk({tag, "_ev_extra"}, 34'(obs_q.size() - rd_idx), 34'd0);
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, input logic la,
                          input logic lb);
    if (la) exp_q.push_back({2'd1, a});
    if (lb) exp_q.push_back({2'd2, b});
    exp_q.push_back({2'd3, op, 28'h0});
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic la,
                       input logic lb, input string tag);
    int n;
    cif.cmd_valid  = 1'b1;
    cif.cmd_a      = a;
    cif.cmd_b      = b;
    cif.cmd_op     = op;
    cif.cmd_load_a = la;
    cif.cmd_load_b = lb;
    n = 0;
    while (!cif.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready_wait"}, 34'(cif.cmd_ready), 34'd1);
  endtask

  task automatic run_cmd(input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic la,
                         input logic lb, input bit keep_valid,
                         input int exp_l, input logic [3:0] fr_val,
                         input string tag);
    int cyc;
    bit got;
    push_exp(a, b, op, la, lb);
    drive(a, b, op, la, lb, tag);
    cyc = 0;
    got = 1'b0;
    while (cyc < 60 && !got) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk({tag, "_busy"}, 34'(busy), 34'd1);
        chk({tag, "_not_ready"}, 34'(cif.cmd_ready), 34'd0);
        if (keep_valid) begin
          cif.cmd_a      = ~a;
          cif.cmd_b      = ~b;
          cif.cmd_op     = ~op;
          cif.cmd_load_a = 1'b1;
          cif.cmd_load_b = 1'b1;
        end else begin
          cif.cmd_valid = 1'b0;
        end
      end
      fr_in = (cyc == exp_l - 1) ? fr_val : 4'h0;
      if (done) got = 1'b1;
    end
    chk({tag, "_latency"}, 34'(cyc), 34'(exp_l));
    chk({tag, "_fr_at_done"}, 34'(fr_out), 34'(fr_val));
    drain(tag);
    if (!keep_valid) begin
      repeat (3) @(negedge clk);
      chk({tag, "_fr_hold"}, 34'(fr_out), 34'(fr_val));
      chk({tag, "_sw_hold"}, 34'(sw), {2'd0, op, 28'h0});
      chk({tag, "_idle_ready"}, 34'(cif.cmd_ready), 34'd1);
      chk({tag, "_idle_busy"}, 34'(busy), 34'd0);
    end
  endtask

  initial begin
    int d0;
    rst            = 1'b1;
    fr_in          = 4'h0;
    cif.cmd_valid  = 1'b0;
    cif.cmd_a      = 32'h0;
    cif.cmd_b      = 32'h0;
    cif.cmd_op     = 4'h0;
    cif.cmd_load_a = 1'b0;
    cif.cmd_load_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sw", 34'(sw), 34'd0);
    chk("rst_strobes", 34'({ld_a, ld_b, ld_f}), 34'd0);
    chk("rst_fr", 34'(fr_out), 34'd0);
    chk("rst_done", 34'(done), 34'd0);
    chk("rst_busy", 34'(busy), 34'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 34'(cif.cmd_ready), 34'd1);

    run_cmd(32'h5, 32'h3, 4'h0, 1'b1, 1'b1, 1'b0, 12, 4'b0101, "ab");
    run_cmd(32'hAAAA_0000, 32'h2, 4'h8, 1'b0, 1'b1, 1'b0, 9,
            4'b1000, "b_only");

    // Reset while ld_b is high.
    push_exp(32'h11, 32'h22, 4'h4, 1'b1, 1'b1);
    void'(exp_q.pop_back());
    drive(32'h11, 32'h22, 4'h4, 1'b1, 1'b1, "mid_rst");
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) cif.cmd_valid = 1'b0;
    end
    chk("mid_rst_in_bpulse", 34'(ld_b), 34'd1);
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ld_b", 34'(ld_b), 34'd0);
    chk("mid_rst_sw", 34'(sw), 34'd0);
    chk("mid_rst_fr", 34'(fr_out), 34'd0);
    chk("mid_rst_busy", 34'(busy), 34'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", 34'(cif.cmd_ready), 34'd1);
    repeat (15) @(negedge clk);
    chk("mid_rst_no_done", 34'(done_cnt - d0), 34'd0);
    drain("mid_rst");

    // Valid held with altered data while busy, then an F-only command.
    run_cmd(32'h7, 32'h9, 4'h3, 1'b1, 1'b1, 1'b1, 12, 4'b0010, "busy_hold");
    run_cmd(32'h0, 32'h0, 4'hD, 1'b0, 1'b0, 1'b0, 6, 4'b0011, "f_only");

    chk("one_strobe", 34'(multi_cnt), 34'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
